dht11_scheduler: RTL and testbench
==================================

# dht11_scheduler

Read scheduler for the single DHT11 reader in the I/O interface. It arbitrates read requests from up to N_REQ requesters, such as the UART command decoder and the display refresher, using round-robin grant. It sequences the reader's `en`/`rst` inputs, enforces the sensor's minimum re-read interval, checks the checksum, and retries on failure. A cached last-good reading is served when a fresh read is not yet allowed.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters.
- `MIN_INTERVAL`, 100_000_000: minimum cycles between read starts (2 s at 50 MHz).
- `MAX_RETRY`, 2: extra read attempts after a failed read.
- `BUSY_TIMEOUT`, 16: cycles allowed for reader `wai` to rise after the reset pulse.
- `DONE_TIMEOUT`, 5_000_000: watchdog on a single read (100 ms).

Ports:
- `clk_50MHz`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  level request; hold until own `gnt` bit.
- `gnt`  out  N_REQ  one-hot, 1-cycle pulse coincident with `rsp_valid`.
- `rsp_valid`  out  1  1-cycle response strobe.
- `rsp_data`  out  40  {hum_int, hum_float, temp_int, temp_float, cs}, MSB first.
- `rsp_status`  out  2  00 fresh OK, 01 cached OK, 10 sensor/timeout error, 11 checksum error.
- `sen_en`  out  1  to reader `en`.
- `sen_rst`  out  1  to reader `rst` (active-high).
- `sen_wai`  in  1  reader busy.
- `sen_error`  in  1  reader error.
- `sen_data`  in  40  reader outputs, packed as for `rsp_data`.

## Operation
- **Reset values:** `gnt`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_status`=00, `sen_en`=0, `sen_rst`=1. Internally: `age` counter = `MIN_INTERVAL` (saturated), `cache_valid`=0, `rr_ptr`=0.
- **`age` counter:** cleared at each read start, increments every cycle, saturates at `MIN_INTERVAL`. A read is "allowed" when `age`==`MIN_INTERVAL`.
- **FSM states:**
  - IDLE: if any `req` bit is set, the round-robin winner (searched from `rr_ptr`) is latched as `owner` and `attempts` is cleared, then go to DECIDE.
  - DECIDE:
    - If a read is allowed, go to PULSE.
    - Else if `cache_valid`, go to RESP with status 01 and the cached data.
    - Else go to HOLDOFF.
  - HOLDOFF: wait until a read is allowed, then go to PULSE.
  - PULSE: `sen_en`=1, `sen_rst`=1 for exactly 1 cycle, clear `age` and `err_seen`, then go to WAIT_BUSY.
  - WAIT_BUSY: `sen_en`=1, `sen_rst`=0. Go to WAIT_DONE when `sen_wai`=1. If `BUSY_TIMEOUT` expires first, the attempt fails with a sensor error.
  - WAIT_DONE:
    - Latch `err_seen` |= `sen_error` every cycle. The reader clears its error before dropping `wai`, so the error must be latched, not sampled at the end.
    - On `sen_wai`=0, go to CHECK.
    - If `DONE_TIMEOUT` expires, the attempt fails with a sensor error.
  - CHECK:
    - If `err_seen`, the attempt fails with a sensor error.
    - Else if the checksum mismatches, the attempt fails with a checksum error.
    - Else store `sen_data` in the cache, set `cache_valid`=1, and go to RESP with status 00.
  - Failure handling: increment `attempts`.
    - If `attempts` ≤ `MAX_RETRY`, go to HOLDOFF.
    - Else clear `cache_valid` and go to RESP with the failure status and `rsp_data`=0.
  - RESP: `rsp_valid`=1 and `gnt[owner]`=1 for 1 cycle, `rr_ptr`=`owner`+1 (mod N_REQ), `sen_en`=0, then go to IDLE.
- **Checksum:** 8-bit sum of the four data bytes, carry discarded, compared against `cs`. Example: 0x37+0x00+0x19+0x00=0x50.
- **Owner is latched:** if `req[owner]` drops mid-read, the read still completes and the response is still pulsed to `owner`.
- **Simultaneous requests:** the lowest index at or after `rr_ptr` wins; the others wait in IDLE for later grants.
- **Reset mid-read:** all state is cleared immediately, `sen_rst` is asserted, and no response is issued.

## Timing
- Cached response: `req` seen in IDLE → `rsp_valid` 2 cycles later (DECIDE, RESP).
- Fresh read: PULSE cycle → reader START on the next cycle → `wai` rises within 2 cycles. Response appears 2 cycles after `wai` falls (CHECK, RESP).
- `sen_en` is held 1 from PULSE through CHECK, and is 0 otherwise.
- `sen_rst` is 1 only in PULSE and during reset.
- Outputs are registered, and the FSM has no combinational path from `req` to `gnt`.

## Structure
- Shared package `dht11_pkg`:
  - the FSM state encoding;
  - the `rsp_status` codes;
  - the byte-field offsets of the 40-bit word;
  - the 50 MHz timing constants (2 s, 100 ms).
- One sub-module, `rr_arbiter`: N_REQ-wide, `rr_ptr`-based, one-hot output. Also reusable for other shared peripherals.
- The checksum is inline in this block.

## Test plan
Use a behavioural reader model; override `MIN_INTERVAL`=1000 and `DONE_TIMEOUT`=500.
- Single request, model returns 0x37_00_19_00_50 → status 00, data matches, `gnt` equals the requester's bit, `sen_rst` pulsed once.
- Second request 200 cycles after the first response → status 01 with the cached data and no `sen_en` activity. Request at `age` ≥ 1000 → a new read.
- `req`=4'b1111 held continuously → four responses granting bits 0, 1, 2, 3 in order, each one-hot.
- Model pulses `sen_error` then drops `wai` on every attempt → 3 reads spaced ≥1000 cycles apart, then status 10, data 0, `cache_valid` cleared.
- Model returns cs=0x51 on the first read and correct data on the second → one retry, then status 00.
- Model never raises `wai` → `BUSY_TIMEOUT` retries end in status 10. Assert `rst_n` mid-WAIT_DONE → all outputs reach their reset values immediately and no `rsp_valid` is issued.

Source files
------------

// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 read scheduler.
//   - FSM state encoding
//   - response status codes
//   - byte-field offsets of the 40-bit reading {hum_int, hum_float, temp_int, temp_float, cs}
//   - 50 MHz timing constants
package dht11_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECIDE,
      S_HOLDOFF,
      S_PULSE,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_CHECK,
      S_RESP
   } state_t;

   typedef enum logic [1:0] {
      ST_FRESH      = 2'b00,
      ST_CACHED     = 2'b01,
      ST_SENSOR_ERR = 2'b10,
      ST_CS_ERR     = 2'b11
   } rsp_status_t;

   localparam int unsigned HUM_INT_LSB = 32;
   localparam int unsigned HUM_FLT_LSB = 24;
   localparam int unsigned TMP_INT_LSB = 16;
   localparam int unsigned TMP_FLT_LSB = 8;
   localparam int unsigned CS_LSB      = 0;

   localparam int unsigned T_2S_50MHZ    = 100_000_000;
   localparam int unsigned T_100MS_50MHZ = 5_000_000;

endpackage

// File: rtl/dht11_scheduler_if.sv
// Requester-side bus of the DHT11 read scheduler.
//   req        : level request per requester, held until its gnt bit
//   gnt        : one-hot grant, 1-cycle pulse with rsp_valid
//   rsp_valid  : 1-cycle response strobe
//   rsp_data   : 40-bit reading, MSB first
//   rsp_status : fresh / cached / sensor error / checksum error
// master = requester side, slave = scheduler side.
interface dht11_scheduler_if #(
   parameter int unsigned N_REQ = 4
);
   import dht11_pkg::*;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic             rsp_valid;
   logic [39:0]      rsp_data;
   rsp_status_t      rsp_status;

   modport master (output req, input gnt, input rsp_valid, input rsp_data, input rsp_status);
   modport slave  (input req, output gnt, output rsp_valid, output rsp_data, output rsp_status);

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter, reusable for any shared peripheral.
//   i_req : request vector
//   i_ptr : highest-priority index; search wraps from here
//   o_gnt : one-hot winner (all zero when no request)
//   o_idx : binary index of the winner
//   o_any : at least one request present
module rr_arbiter #(
   parameter  int unsigned N  = 4,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   logic [IW-1:0] w_cand;

   always_comb begin
      o_gnt  = '0;
      o_idx  = '0;
      o_any  = 1'b0;
      w_cand = '0;
      for (int unsigned k = 0; k < N; k++) begin
         w_cand = IW'((32'(i_ptr) + k) % N);
         if (!o_any && i_req[w_cand]) begin
            o_any         = 1'b1;
            o_idx         = w_cand;
            o_gnt[w_cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dht11_scheduler.sv
// Read scheduler for a single DHT11 reader shared by N_REQ requesters.
// Round-robin grant, enforced minimum re-read interval, checksum check,
// bounded retries, and a cached last-good reading served when a fresh
// read is not yet allowed.
//   clk_50MHz, rst_n : clock, asynchronous active-low reset
//   bus              : requester bus (req in; gnt/rsp_* out)
//   sen_en, sen_rst  : to reader en / rst (rst active-high)
//   sen_wai          : reader busy
//   sen_error        : reader error
//   sen_data         : reader 40-bit result
module dht11_scheduler
   import dht11_pkg::*;
#(
   parameter int unsigned N_REQ        = 4,
   parameter int unsigned MIN_INTERVAL = T_2S_50MHZ,
   parameter int unsigned MAX_RETRY    = 2,
   parameter int unsigned BUSY_TIMEOUT = 16,
   parameter int unsigned DONE_TIMEOUT = T_100MS_50MHZ
) (
   input  logic                clk_50MHz,
   input  logic                rst_n,
   dht11_scheduler_if.slave    bus,
   output logic                sen_en,
   output logic                sen_rst,
   input  logic                sen_wai,
   input  logic                sen_error,
   input  logic [39:0]         sen_data
);

   localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t           r_state;
   logic [IW-1:0]    r_owner;
   logic [N_REQ-1:0] r_owner_oh;
   logic [IW-1:0]    r_rr_ptr;
   logic [31:0]      r_attempts;
   logic [31:0]      r_tmo;
   logic [31:0]      r_age;
   logic             r_err_seen;
   logic [39:0]      r_cache;
   logic             r_cache_valid;
   logic [N_REQ-1:0] r_gnt;
   logic             r_rsp_valid;
   logic [39:0]      r_rsp_data;
   rsp_status_t      r_rsp_status;
   logic             r_sen_en;
   logic             r_sen_rst;

   logic [N_REQ-1:0] w_arb_gnt;
   logic [IW-1:0]    w_arb_idx;
   logic             w_arb_any;
   logic             w_allowed;
   logic [7:0]       w_cs_sum;
   logic             w_fail;
   rsp_status_t      w_fail_st;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .i_req (bus.req),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_arb_gnt),
      .o_idx (w_arb_idx),
      .o_any (w_arb_any)
   );

   assign w_allowed = (r_age == MIN_INTERVAL);
   assign w_cs_sum  = sen_data[HUM_INT_LSB +: 8] + sen_data[HUM_FLT_LSB +: 8]
                    + sen_data[TMP_INT_LSB +: 8] + sen_data[TMP_FLT_LSB +: 8];

   // Time since the last read start, saturating once a new read is allowed.
   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n)                    r_age <= MIN_INTERVAL;
      else if (r_state == S_PULSE)   r_age <= '0;
      else if (r_age != MIN_INTERVAL) r_age <= r_age + 1;
   end

   // All attempt-failure causes funnel into one retry/give-up path in the FSM.
   always_comb begin
      w_fail    = 1'b0;
      w_fail_st = ST_SENSOR_ERR;
      case (r_state)
         S_WAIT_BUSY: w_fail = !sen_wai && (r_tmo == BUSY_TIMEOUT - 1);
         S_WAIT_DONE: w_fail = sen_wai && (r_tmo == DONE_TIMEOUT - 1);
         S_CHECK: begin
            w_fail = r_err_seen || (w_cs_sum != sen_data[CS_LSB +: 8]);
            if (!r_err_seen) w_fail_st = ST_CS_ERR;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_owner       <= '0;
         r_owner_oh    <= '0;
         r_rr_ptr      <= '0;
         r_attempts    <= '0;
         r_tmo         <= '0;
         r_err_seen    <= 1'b0;
         r_cache       <= '0;
         r_cache_valid <= 1'b0;
         r_gnt         <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_data    <= '0;
         r_rsp_status  <= ST_FRESH;
         r_sen_en      <= 1'b0;
         r_sen_rst     <= 1'b1;
      end else begin
         // Pulsed outputs default low; set only on the transition into their state.
         r_gnt       <= '0;
         r_rsp_valid <= 1'b0;
         r_sen_rst   <= 1'b0;
         if (w_fail) begin
            r_sen_en   <= 1'b0;
            r_attempts <= r_attempts + 1;
            if (r_attempts < MAX_RETRY) begin
               r_state <= S_HOLDOFF;
            end else begin
               r_cache_valid <= 1'b0;
               r_rsp_valid   <= 1'b1;
               r_gnt         <= r_owner_oh;
               r_rsp_data    <= '0;
               r_rsp_status  <= w_fail_st;
               r_state       <= S_RESP;
            end
         end else begin
            case (r_state)
               S_IDLE: if (w_arb_any) begin
                  r_owner    <= w_arb_idx;
                  r_owner_oh <= w_arb_gnt;
                  r_attempts <= '0;
                  r_state    <= S_DECIDE;
               end
               S_DECIDE: begin
                  if (w_allowed) begin
                     r_sen_en  <= 1'b1;
                     r_sen_rst <= 1'b1;
                     r_state   <= S_PULSE;
                  end else if (r_cache_valid) begin
                     r_rsp_valid  <= 1'b1;
                     r_gnt        <= r_owner_oh;
                     r_rsp_data   <= r_cache;
                     r_rsp_status <= ST_CACHED;
                     r_state      <= S_RESP;
                  end else begin
                     r_state <= S_HOLDOFF;
                  end
               end
               S_HOLDOFF: if (w_allowed) begin
                  r_sen_en  <= 1'b1;
                  r_sen_rst <= 1'b1;
                  r_state   <= S_PULSE;
               end
               S_PULSE: begin
                  r_err_seen <= 1'b0;
                  r_tmo      <= '0;
                  r_state    <= S_WAIT_BUSY;
               end
               S_WAIT_BUSY: begin
                  if (sen_wai) begin
                     r_tmo   <= '0;
                     r_state <= S_WAIT_DONE;
                  end else begin
                     r_tmo <= r_tmo + 1;
                  end
               end
               S_WAIT_DONE: begin
                  // Reader clears its error before dropping wai, so latch it.
                  r_err_seen <= r_err_seen | sen_error;
                  if (!sen_wai) r_state <= S_CHECK;
                  else          r_tmo   <= r_tmo + 1;
               end
               S_CHECK: begin
                  r_sen_en      <= 1'b0;
                  r_cache       <= sen_data;
                  r_cache_valid <= 1'b1;
                  r_rsp_valid   <= 1'b1;
                  r_gnt         <= r_owner_oh;
                  r_rsp_data    <= sen_data;
                  r_rsp_status  <= ST_FRESH;
                  r_state       <= S_RESP;
               end
               S_RESP: begin
                  r_rr_ptr <= (32'(r_owner) == N_REQ - 1) ? '0 : r_owner + IW'(1);
                  r_sen_en <= 1'b0;
                  r_state  <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.gnt        = r_gnt;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_data   = r_rsp_data;
   assign bus.rsp_status = r_rsp_status;
   assign sen_en         = r_sen_en;
   assign sen_rst        = r_sen_rst;

endmodule

// File: tb/tb_dht11_scheduler.sv
// Directed self-checking bench for dht11_scheduler with a behavioural DHT11 reader model.
module tb_dht11_scheduler;

   localparam int unsigned NR = 4;
   localparam int MD_OK    = 0;  // normal read
   localparam int MD_ERR   = 1;  // pulse sen_error mid-read
   localparam int MD_NOWAI = 2;  // never raise wai
   localparam int MD_HANG  = 3;  // raise wai, never drop it

   logic        clk_50MHz = 1'b0;
   logic        rst_n;
   logic        sen_en, sen_rst, sen_wai, sen_error;
   logic [39:0] sen_data;

   dht11_scheduler_if #(.N_REQ(NR)) bus();

   dht11_scheduler #(
      .N_REQ        (NR),
      .MIN_INTERVAL (1000),
      .MAX_RETRY    (2),
      .BUSY_TIMEOUT (16),
      .DONE_TIMEOUT (500)
   ) dut (
      .clk_50MHz (clk_50MHz),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .sen_en    (sen_en),
      .sen_rst   (sen_rst),
      .sen_wai   (sen_wai),
      .sen_error (sen_error),
      .sen_data  (sen_data)
   );

   always #5 clk_50MHz = ~clk_50MHz;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc      = 0;
   int          n_en     = 0;
   int          n_rsp    = 0;
   int          n_start  = 0;
   int          pulse_t[$];
   int          m_mode;
   int          m_bad_at;
   logic [39:0] m_good, m_bad;
   logic [7:0]  m_cnt;
   logic        m_armed;

   logic [NR-1:0] c_gnt;
   logic [39:0]   c_data;
   logic [1:0]    c_status;
   int            c_lat;
   logic          c_ok;

   // Reader model: armed by the rst pulse, starts when en is seen with rst low.
   always @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         sen_wai <= 1'b0; sen_error <= 1'b0; sen_data <= '0; m_cnt <= '0; m_armed <= 1'b0;
      end else if (sen_rst) begin
         sen_wai <= 1'b0; sen_error <= 1'b0; m_cnt <= '0; m_armed <= 1'b1;
      end else if (m_armed && sen_en) begin
         m_armed  <= 1'b0;
         n_start  <= n_start + 1;
         sen_data <= (n_start == m_bad_at) ? m_bad : m_good;
         if (m_mode != MD_NOWAI) begin
            sen_wai <= 1'b1;
            m_cnt   <= 8'd1;
         end
      end else if (m_cnt != 0) begin
         m_cnt <= m_cnt + 8'd1;
         if (m_mode == MD_ERR) sen_error <= (m_cnt >= 5 && m_cnt < 8);
         if (m_cnt == 20 && m_mode != MD_HANG) begin
            sen_wai <= 1'b0;
            m_cnt   <= '0;
         end
      end
   end

   always @(negedge clk_50MHz) begin
      cyc <= cyc + 1;
      if (rst_n && sen_rst) pulse_t.push_back(cyc);
      if (sen_en) n_en <= n_en + 1;
      if (bus.rsp_valid) n_rsp <= n_rsp + 1;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Waits a bounded number of cycles for rsp_valid and captures the response.
   task automatic wait_rsp(input string tag, input int budget, input logic drop);
      int k = 0;
      c_ok = 1'b0;
      while (k < budget && !c_ok) begin
         @(negedge clk_50MHz);
         k++;
         if (bus.rsp_valid) begin
            c_ok     = 1'b1;
            c_gnt    = bus.gnt;
            c_data   = bus.rsp_data;
            c_status = bus.rsp_status;
            c_lat    = k;
            if (drop) bus.req = bus.req & ~bus.gnt;
         end
      end
      check_eq({tag, "_rsp_seen"}, 64'(c_ok), 64'd1);
   endtask

   function automatic int gap(input int idx);
      if (pulse_t.size() > idx + 1) return pulse_t[idx+1] - pulse_t[idx];
      return 0;
   endfunction

   int p0, e0, r0, k;
   logic [NR-1:0] exp_g;

   initial begin
      m_mode   = MD_OK;
      m_bad_at = -1;
      m_good   = 40'h37_00_19_00_50;
      m_bad    = 40'h37_00_19_00_51;
      rst_n    = 1'b0;
      bus.req  = '0;
      repeat (3) @(negedge clk_50MHz);
      check_eq("rst_gnt",    64'(bus.gnt), 64'd0);
      check_eq("rst_valid",  64'(bus.rsp_valid), 64'd0);
      check_eq("rst_data",   64'(bus.rsp_data), 64'd0);
      check_eq("rst_status", 64'(bus.rsp_status), 64'd0);
      check_eq("rst_sen_en", 64'(sen_en), 64'd0);
      check_eq("rst_sen_rst", 64'(sen_rst), 64'd1);
      rst_n = 1'b1;
      repeat (5) @(negedge clk_50MHz);

      // First read, requester 0
      p0 = pulse_t.size();
      bus.req = 4'b0001;
      wait_rsp("t1", 200, 1'b1);
      check_eq("t1_gnt",    64'(c_gnt), 64'h1);
      check_eq("t1_data",   64'(c_data), 64'h37_00_19_00_50);
      check_eq("t1_status", 64'(c_status), 64'd0);
      check_eq("t1_pulses", 64'(pulse_t.size() - p0), 64'd1);
      check_eq("t1_sen_rst_low", 64'(sen_rst), 64'd0);

      // Cached response within the interval
      repeat (200) @(negedge clk_50MHz);
      e0 = n_en;
      bus.req = 4'b0010;
      wait_rsp("t2", 20, 1'b1);
      check_eq("t2_gnt",    64'(c_gnt), 64'h2);
      check_eq("t2_data",   64'(c_data), 64'h37_00_19_00_50);
      check_eq("t2_status", 64'(c_status), 64'd1);
      check_eq("t2_latency", 64'(c_lat), 64'd2);
      check_eq("t2_no_en",  64'(n_en - e0), 64'd0);

      // Interval elapsed: fresh read with new data
      repeat (1000) @(negedge clk_50MHz);
      m_good = 40'h2D_05_17_03_4C;
      p0 = pulse_t.size();
      bus.req = 4'b1000;
      wait_rsp("t2b", 200, 1'b1);
      check_eq("t2b_gnt",    64'(c_gnt), 64'h8);
      check_eq("t2b_data",   64'(c_data), 64'h2D_05_17_03_4C);
      check_eq("t2b_status", 64'(c_status), 64'd0);
      check_eq("t2b_pulses", 64'(pulse_t.size() - p0), 64'd1);

      // All four held: rr order 0,1,2,3 from cache
      bus.req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         wait_rsp("t3", 20, 1'b0);
         exp_g = 4'b0001 << i;
         check_eq("t3_gnt",    64'(c_gnt), 64'(exp_g));
         check_eq("t3_status", 64'(c_status), 64'd1);
      end
      bus.req = '0;
      check_eq("t3_data", 64'(c_data), 64'h2D_05_17_03_4C);

      // Reader error on every attempt
      repeat (1100) @(negedge clk_50MHz);
      m_mode = MD_ERR;
      p0 = pulse_t.size();
      bus.req = 4'b0001;
      wait_rsp("t4", 5000, 1'b1);
      check_eq("t4_gnt",    64'(c_gnt), 64'h1);
      check_eq("t4_status", 64'(c_status), 64'd2);
      check_eq("t4_data",   64'(c_data), 64'd0);
      check_eq("t4_pulses", 64'(pulse_t.size() - p0), 64'd3);
      check_eq("t4_gap1_ge1000", 64'(gap(p0) >= 1000), 64'd1);
      check_eq("t4_gap2_ge1000", 64'(gap(p0 + 1) >= 1000), 64'd1);

      // Bad checksum then good; cache was cleared so no cached answer
      m_mode   = MD_OK;
      m_good   = 40'h37_00_19_00_50;
      m_bad_at = n_start;
      p0 = pulse_t.size();
      bus.req = 4'b0010;
      wait_rsp("t5", 5000, 1'b1);
      check_eq("t5_gnt",    64'(c_gnt), 64'h2);
      check_eq("t5_status", 64'(c_status), 64'd0);
      check_eq("t5_data",   64'(c_data), 64'h37_00_19_00_50);
      check_eq("t5_pulses", 64'(pulse_t.size() - p0), 64'd2);

      // Reader never goes busy
      repeat (1100) @(negedge clk_50MHz);
      m_mode = MD_NOWAI;
      p0 = pulse_t.size();
      bus.req = 4'b0100;
      wait_rsp("t6", 5000, 1'b1);
      check_eq("t6_gnt",    64'(c_gnt), 64'h4);
      check_eq("t6_status", 64'(c_status), 64'd2);
      check_eq("t6_data",   64'(c_data), 64'd0);
      check_eq("t6_pulses", 64'(pulse_t.size() - p0), 64'd3);

      // Reset during WAIT_DONE
      m_mode = MD_HANG;
      bus.req = 4'b1000;
      k = 0;
      while (k < 3000 && !sen_wai) begin
         @(negedge clk_50MHz);
         k++;
      end
      check_eq("t7_wai_seen", 64'(sen_wai), 64'd1);
      repeat (5) @(negedge clk_50MHz);
      r0 = n_rsp;
      #2 rst_n = 1'b0;
      #1;
      check_eq("t7_sen_rst", 64'(sen_rst), 64'd1);
      check_eq("t7_sen_en",  64'(sen_en), 64'd0);
      check_eq("t7_gnt",     64'(bus.gnt), 64'd0);
      check_eq("t7_valid",   64'(bus.rsp_valid), 64'd0);
      check_eq("t7_data",    64'(bus.rsp_data), 64'd0);
      check_eq("t7_status",  64'(bus.rsp_status), 64'd0);
      bus.req = '0;
      repeat (3) @(negedge clk_50MHz);
      rst_n = 1'b1;
      repeat (600) @(negedge clk_50MHz);
      check_eq("t7_no_rsp",    64'(n_rsp - r0), 64'd0);
      check_eq("t7_idle_en",   64'(sen_en), 64'd0);
      check_eq("t7_idle_rst",  64'(sen_rst), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
